// File: rtl/pw_entry_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pw_entry_ctrl_if
// Description : Switch/lock-request inputs and indicator/display outputs of
//               the password entry controller, bundled as one interface.
//               master = switch panel / display side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pw_entry_ctrl_if;
    logic [9:0] sw;
    logic       lock_req;
    logic       open;
    logic       alarm;
    logic [2:0] digit_idx;
    logic [3:0] last_digit;
    logic [3:0] fail_cnt;
    logic [5:0] states;

    modport master (
        output sw, lock_req,
        input  open, alarm, digit_idx, last_digit, fail_cnt, states
    );

    modport slave (
        input  sw, lock_req,
        output open, alarm, digit_idx, last_digit, fail_cnt, states
    );
endinterface
`default_nettype wire

// File: rtl/pw_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pw_entry_ctrl
// Description : Password lock sequencer. Converts switch presses into digits,
//               collects four-digit attempts against the stored code, counts
//               consecutive failures and enforces a timed lockout.
//               Optional feature macro: PW_PROGRAM_EN (code programming from
//               OPEN via a sw[9] press).
// Revision    : 1.0 - initial release
// ============================================================================
module pw_entry_ctrl #(
    parameter logic [15:0] DEFAULT_CODE = 16'h3210,
    parameter int          MAX_FAILS    = 3,
    parameter int          LOCK_CYCLES  = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    pw_entry_ctrl_if.slave   bus
);

    // Timer only ever holds LOCK_CYCLES-1 down to 0.
    localparam int                 TIMER_W       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD    = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE     = TIMER_W'(1);
    localparam logic [3:0]         FAIL_MAX      = 4'(MAX_FAILS);
    localparam logic [4:0]         FAIL_LIMIT    = 5'(MAX_FAILS);
    localparam logic [3:0]         DIGIT_INVALID = 4'hF;
`ifdef PW_PROGRAM_EN
    localparam logic [9:0]         PROG_KEY      = 10'h200;
`endif

    // One-hot state encoding doubles as the 'states' display output.
    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_ENTRY = 6'b000010,
        S_OPEN  = 6'b000100,
        S_FAIL  = 6'b001000,
        S_LOCK  = 6'b010000
`ifdef PW_PROGRAM_EN
        , S_PROG = 6'b100000
`endif
    } state_t;

    state_t               state;
    logic [9:0]           sw_q;
    logic [15:0]          code;
    logic                 mismatch;
    logic [TIMER_W-1:0]   timer;
    logic                 open_q;
    logic                 alarm_q;
    logic [2:0]           idx_q;
    logic [3:0]           last_q;
    logic [3:0]           fails_q;

    logic                 press;
    logic                 one_hot;
    logic [3:0]           digit;
    logic [3:0]           code_digit;
    logic                 digit_bad;
    logic [4:0]           fails_inc;

    // Previous switch sample; deliberately not reset so a switch held
    // through reset is not seen as a fresh press afterwards.
    always_ff @(posedge clk) begin
        sw_q <= bus.sw;
    end

    // Press detection and switch-to-digit decode.
    always_comb begin
        press   = (bus.sw != 10'd0) && (sw_q == 10'd0);
        one_hot = $onehot(bus.sw);
        digit   = DIGIT_INVALID;
        for (int i = 0; i < 10; i++) begin
            if (one_hot && bus.sw[i]) begin
                digit = 4'(i);
            end
        end
    end

    assign code_digit = code[{idx_q[1:0], 2'b00} +: 4];
    assign digit_bad  = (digit != code_digit);
    assign fails_inc  = {1'b0, fails_q} + 5'd1;

`ifdef PW_PROGRAM_EN
    logic [15:0] shadow;
    logic [15:0] shadow_next;

    // Shadow code with the current press written into slot digit_idx.
    always_comb begin
        shadow_next = shadow;
        shadow_next[{idx_q[1:0], 2'b00} +: 4] = digit;
    end
`else
    assign code = DEFAULT_CODE;
`endif

    // Main sequencer: state, counters, timer and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            mismatch <= 1'b0;
            timer    <= '0;
            open_q   <= 1'b0;
            alarm_q  <= 1'b0;
            idx_q    <= 3'd0;
            last_q   <= 4'd0;
            fails_q  <= 4'd0;
`ifdef PW_PROGRAM_EN
            code     <= DEFAULT_CODE;
            shadow   <= DEFAULT_CODE;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (press) begin
                        state    <= S_ENTRY;
                        idx_q    <= 3'd1;
                        mismatch <= (digit != code[3:0]);
                        last_q   <= digit;
                    end
                end

                S_ENTRY: begin
                    if (press) begin
                        last_q <= digit;
                        idx_q  <= idx_q + 3'd1;
                        if (idx_q == 3'd3) begin
                            // Attempt complete: judged on this same edge.
                            mismatch <= 1'b0;
                            if (!(mismatch || digit_bad)) begin
                                state   <= S_OPEN;
                                open_q  <= 1'b1;
                                fails_q <= 4'd0;
                            end else if (fails_inc >= FAIL_LIMIT) begin
                                state   <= S_LOCK;
                                alarm_q <= 1'b1;
                                fails_q <= FAIL_MAX;
                                timer   <= TIMER_LOAD;
                            end else begin
                                state   <= S_FAIL;
                                fails_q <= fails_inc[3:0];
                            end
                        end else begin
                            mismatch <= mismatch | digit_bad;
                        end
                    end
                end

                S_FAIL: begin
                    if (bus.sw == 10'd0) begin
                        state <= S_IDLE;
                        idx_q <= 3'd0;
                    end
                end

                S_LOCK: begin
                    // Loaded with LOCK_CYCLES-1, so alarm lasts LOCK_CYCLES cycles.
                    if (timer == '0) begin
                        state   <= S_IDLE;
                        alarm_q <= 1'b0;
                        fails_q <= 4'd0;
                        idx_q   <= 3'd0;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end

                S_OPEN: begin
                    // lock_req has priority over any press in the same cycle.
                    if (bus.lock_req) begin
                        state  <= S_IDLE;
                        open_q <= 1'b0;
                        idx_q  <= 3'd0;
                    end
`ifdef PW_PROGRAM_EN
                    else if (press && (bus.sw == PROG_KEY)) begin
                        state <= S_PROG;
                        idx_q <= 3'd0;
                    end
`endif
                end

`ifdef PW_PROGRAM_EN
                S_PROG: begin
                    if (bus.lock_req) begin
                        state  <= S_IDLE;
                        open_q <= 1'b0;
                        idx_q  <= 3'd0;
                    end else if (press) begin
                        if (one_hot) begin
                            shadow <= shadow_next;
                            last_q <= digit;
                            if (idx_q == 3'd3) begin
                                code  <= shadow_next;
                                state <= S_OPEN;
                                idx_q <= 3'd4;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else begin
                            // Abort; the stored code is untouched.
                            state <= S_OPEN;
                            idx_q <= 3'd0;
                        end
                    end
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.open       = open_q;
    assign bus.alarm      = alarm_q;
    assign bus.digit_idx  = idx_q;
    assign bus.last_digit = last_q;
    assign bus.fail_cnt   = fails_q;
    assign bus.states     = state;

endmodule
`default_nettype wire

// File: doc/pw_entry_ctrl.md
# pw_entry_ctrl

Sequencing controller for the switch-driven password lock. It turns `sw` switch presses into digit events and collects fixed four-digit attempts against a stored code. It counts failed attempts and enforces a timed lockout after too many failures. Its outputs drive the lock indicators and supply `last_digit`, `digit_idx`, `fail_cnt` and `states` to the seven-segment/LED display logic.

## Interface
- `DEFAULT_CODE`, 16'h3210: reset code, four 4-bit digits; digit 0 in [3:0], entered first.
- `MAX_FAILS`, 3: consecutive failed attempts that trigger lockout; range 1..15.
- `LOCK_CYCLES`, 50_000_000: lockout duration in clock cycles; must be ≥1.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous and active-low.
- `sw`  in  10  switch bank; `sw[i]` alone means digit i.
- `lock_req`  in  1  one-cycle pulse; relocks from OPEN (and PROG).
- `open`  out  1  high while in OPEN or PROG.
- `alarm`  out  1  high while in LOCKOUT.
- `digit_idx`  out  3  digits collected in the current attempt, 0..4.
- `last_digit`  out  4  most recent accepted digit; 4'hF means invalid.
- `fail_cnt`  out  4  consecutive failed attempts.
- `states`  out  6  one-hot state: [0] IDLE, [1] ENTRY, [2] OPEN, [3] FAIL, [4] LOCKOUT, [5] PROG.

## Operation
- `sw_q` register samples `sw` every cycle, including during reset. A switch held through reset is therefore not a press.
- Press event: `sw != 0` and `sw_q == 0`.
- Press digit:
  - Exactly one bit set: digit = index of that bit.
  - Any other pattern: digit = 4'hF, which never matches a stored digit.
- IDLE:
  - On a press: go to ENTRY and set `digit_idx` = 1.
  - Mismatch flag = (digit != code digit 0).
  - `last_digit` = digit.
- ENTRY:
  - Each press ORs its mismatch into the flag, increments `digit_idx` and updates `last_digit`.
  - There is no early exit on a wrong digit; all four digits are always collected.
- Fourth press evaluation, on the same edge as the press:
  - Match: go to OPEN and clear `fail_cnt`.
  - Mismatch with `fail_cnt+1 == MAX_FAILS`: go to LOCKOUT, set `fail_cnt` = MAX_FAILS and load the timer with LOCK_CYCLES−1.
  - Other mismatch: go to FAIL and increment `fail_cnt`.
- FAIL: waits until `sw == 0`, then goes to IDLE with `digit_idx` = 0.
- LOCKOUT:
  - Presses are ignored and the timer decrements each cycle.
  - In the cycle the timer reaches 0: go to IDLE, clear `fail_cnt` and `digit_idx`.
  - `alarm` is high for exactly LOCK_CYCLES cycles.
- OPEN:
  - `lock_req` goes to IDLE with `digit_idx` = 0.
  - Presses are ignored, except for the behaviour under Configuration.
- `lock_req` outside OPEN/PROG is ignored.
- `fail_cnt` saturates at MAX_FAILS.
- Reset values (`rst` low at an edge):
  - State IDLE, `states` = 6'b000001.
  - `open` = 0, `alarm` = 0, `digit_idx` = 0, `last_digit` = 0, `fail_cnt` = 0.
  - Timer = 0, mismatch flag = 0, code register = DEFAULT_CODE.
- Reset in any state, including mid-entry and mid-lockout, aborts immediately.

## Timing
- All outputs are registered. A press sampled at edge N is reflected in the outputs after edge N.
- Press-to-OPEN, FAIL or LOCKOUT latency is one cycle after the fourth press edge.
- `lock_req` takes effect on the edge where it is sampled high.
- A `lock_req` and a press in the same cycle in OPEN: `lock_req` wins and the press is discarded.
- A release followed by a re-press needs at least one cycle with `sw == 0`. Bit changes while `sw` stays nonzero are not new presses.

## Configuration
- `PW_PROGRAM_EN` defined:
  - In OPEN, a press of exactly `sw[9]` enters PROG with `digit_idx` = 0.
  - Each following valid one-hot press writes the next code digit into a shadow register.
  - After the fourth digit, the shadow register is copied into the code register and the state returns to OPEN.
  - A non-one-hot press or `lock_req` aborts and leaves the old code intact. Non-one-hot returns to OPEN; `lock_req` goes to IDLE.
- `PW_PROGRAM_EN` undefined:
  - The code is fixed at DEFAULT_CODE and no PROG state exists.
  - `states[5]` is tied to 0 and `sw[9]` in OPEN is ignored.

## Test plan
- Reset, then presses of `sw[0]`, `sw[1]`, `sw[2]`, `sw[3]`, each 30 ns with 30 ns release → `open`=1 and `states`=6'b000100 one cycle after the fourth press; `fail_cnt`=0.
- Enter 0,1,2,4 → `states`=6'b001000 and `fail_cnt`=1; after release → IDLE with `digit_idx`=0.
- With LOCK_CYCLES=8, enter three wrong codes → `alarm`=1 for exactly 8 cycles; presses during lockout do not change `digit_idx`; afterwards IDLE with `fail_cnt`=0.
- Press `sw`=10'b0000000011 as the first digit, then 1,2,3 → `last_digit`=4'hF after the first press; result is FAIL.
- Hold `sw[0]` through reset release → no press counted (`digit_idx`=0). Separately, enter 0,1 then assert reset → all outputs at their reset values.
- With `PW_PROGRAM_EN`: in OPEN, press `sw[9]`, then 5,6,7,8, then pulse `lock_req`, then enter 5,6,7,8 → `open`=1. Entering 0,1,2,3 afterwards → FAIL.
